uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmitter, the successor to the fixed 8-bit byte transmitter. It supports a configurable data width, runtime-selectable parity and 1 or 2 stop bits, on top of the same 3-bit baud-rate table. It sits between a byte or string sequencer and the `rs232_tx` pad, and keeps the `send_en` / `tx_done` / `uart_state` handshake so existing string senders reuse it unchanged.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `DATA_W`, 8: data bits per frame, legal range 5..9.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `data_in`  in  DATA_W: payload, sent LSB first.
- `send_en`  in  1: start request, sampled on every edge.
- `baud_set`  in  3: baud select, latched at accept.
- `parity_mode`  in  2: 00 none, 01 odd, 10 even, 11 none. Latched at accept.
- `stop2`  in  1: 0 selects one stop bit, 1 selects two. Latched at accept.
- `rs232_tx`  out  1: serial line, registered, idles high.
- `tx_done`  out  1: one-cycle pulse at frame end.
- `uart_state`  out  1: busy flag, high while a frame is in flight.

## Operation
- Baud table (`baud_set` value: rate): 0: 9600, 1: 19200, 2: 38400, 3: 57600, 4: 115200, 5: 230400, 6: 460800, 7: 921600.
- Divider: DIV = round(CLK_FREQ / baud), computed at elaboration. At 50 MHz, DIV = 5208 at 9600 and DIV = 434 at 115200.
- Accept: on an edge where `send_en` = 1 and `uart_state` = 0, the block latches `data_in`, `baud_set`, `parity_mode` and `stop2`.
- Ignored requests: `send_en` is ignored while `uart_state` = 1, including the `tx_done` cycle.
- FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
  - PARITY is skipped when parity is none.
  - DATA advances through bits 0..DATA_W-1.
  - STOP lasts 1 or 2 bit periods.
- Bit period: every state bit lasts exactly DIV clocks. A bit counter (4 bits) and a divider counter (13 bits, sized from the worst-case DIV) control timing.
- Parity: even gives the XOR of the data bits; odd gives its inverse.
- Frame length: N = 1 + DATA_W + P + S, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- Reset values: `rs232_tx` = 1, `tx_done` = 0, `uart_state` = 0, FSM in IDLE, counters at 0.
- Reset mid-frame: the frame is aborted. The line is high after the reset edge, and no `tx_done` is issued.
- Inputs after accept: changes to `data_in` or the config inputs have no effect on the frame in flight.

## Timing
- Accept edge A: `uart_state` ← 1 and `rs232_tx` ← 0 at edge A. Start-bit low lasts DIV clocks.
- Bit k of the frame (k = 0 is the start bit) is driven from edge A + k·DIV to A + (k+1)·DIV.
- `tx_done` is high for exactly one clock: from edge A + N·DIV − 1 to A + N·DIV.
- At edge A + N·DIV: `uart_state` ← 0 and `rs232_tx` stays 1.
- Earliest next accept: edge A + N·DIV + 1.
- Latency from accept to first line transition: 0 clocks; the line changes at the accept edge.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state and parity logic are present, and `parity_mode` behaves as described above.
- Undefined: the PARITY state and parity logic are removed, and `parity_mode` is accepted but ignored. Every frame is sent with no parity bit (P = 0). Port list is identical in both builds.

## Structure
- Package `uart_tx_pkg` holds:
  - the state enum;
  - the parity-mode constants;
  - the baud-rate array;
  - the function `baud_div(clk_freq, sel)` that returns the rounded divider;
  - the divider counter width constant.
- Sub-module `uart_baud_tick`:
  - loads DIV at accept;
  - produces `bit_end`, a one-clock strobe on the last clock of each bit period;
  - is cleared by `rst` or whenever idle.
- The top level holds the FSM, the shift register, the bit counter and the parity accumulator.

## Test plan
All scenarios use CLK_FREQ = 50 MHz and `baud_set` = 4 (DIV = 434) unless stated otherwise.
1. 0xAA, no parity, 1 stop → line 0,0,1,0,1,0,1,0,1,1, each bit 434 clocks; `tx_done` high at A + 4339 for one clock; `uart_state` low at A + 4340.
2. 0x55, even parity, 1 stop → parity bit 0; `tx_done` at A + 4773. Same frame with odd parity → parity bit 1.
3. 0x55, no parity, `stop2` = 1 → 11-bit frame; `tx_done` at A + 4773. Then a second `send_en` at A + 4775 → new start bit at A + 4775.
4. `send_en` pulses at A + 100 and in the `tx_done` cycle → both ignored; exactly one frame and one `tx_done`.
5. `rst` asserted at A + 2000 → `rs232_tx` = 1 and `uart_state` = 0 after that edge; no `tx_done` pulse; next `send_en` starts a clean frame.
6. DATA_W = 9, `baud_set` = 0 (DIV = 5208), 9'h1FF, odd parity → 9 ones then parity 0; N = 12 and `tx_done` at A + 62495. Rebuilt without `UART_TX_PARITY_EN` → N = 11.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared constants for the parametrised UART transmitter.
//   - FSM state encoding (3-bit constants)
//   - parity-mode encodings
//   - baud-rate table indexed by the 3-bit baud select
//   - baud_div(): rounded clocks-per-bit divider, used at elaboration only
//   - DIV_W: divider counter width, sized for the slowest rate (9600 baud)
package uart_tx_pkg;

    localparam int DIV_W = 13;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE3 = 2'b11;

    localparam int unsigned BAUD_RATE [8] = '{
        9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600
    };

    // Round to nearest: add half the divisor before the integer divide.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input logic [2:0]  sel);
        return (clk_freq + BAUD_RATE[sel] / 2) / BAUD_RATE[sel];
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer for the UART transmitter.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   idle          - transmitter idle; holds the counter at zero
//   load          - frame accept; latches the divider for baud_set
//   baud_set      - 3-bit baud select
//   bit_end       - one-clock strobe on the last clock of every bit period
module uart_baud_tick
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       idle,
    input  logic       load,
    input  logic [2:0] baud_set,
    output logic       bit_end
);

    // Divider minus one for every select value, resolved at elaboration so
    // no runtime divider is built.
    localparam logic [DIV_W-1:0] DIV_M1 [8] = '{
        DIV_W'(baud_div(CLK_FREQ, 3'd0) - 1), DIV_W'(baud_div(CLK_FREQ, 3'd1) - 1),
        DIV_W'(baud_div(CLK_FREQ, 3'd2) - 1), DIV_W'(baud_div(CLK_FREQ, 3'd3) - 1),
        DIV_W'(baud_div(CLK_FREQ, 3'd4) - 1), DIV_W'(baud_div(CLK_FREQ, 3'd5) - 1),
        DIV_W'(baud_div(CLK_FREQ, 3'd6) - 1), DIV_W'(baud_div(CLK_FREQ, 3'd7) - 1)
    };

    logic [DIV_W-1:0] div_m1;
    logic [DIV_W-1:0] cnt;

    assign bit_end = !idle && (cnt == div_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_m1 <= '0;
            cnt    <= '0;
        end else begin
            if (load)
                div_m1 <= DIV_M1[baud_set];
            // The accept edge sees idle=1, so the first bit starts at cnt=0.
            if (idle || bit_end)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (DATA_W 5..9, optional
// parity, 1 or 2 stop bits, 8-entry baud table).
// Build option: define UART_TX_PARITY_EN to include the parity bit; without
// it parity_mode is ignored and frames never carry parity.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   data_in      - payload, sent LSB first
//   send_en      - start request, honoured only when idle
//   baud_set     - baud select, latched at accept
//   parity_mode  - 00/11 none, 01 odd, 10 even, latched at accept
//   stop2        - 1 = two stop bits, latched at accept
//   rs232_tx     - registered serial line, idles high
//   tx_done      - one-clock pulse in the last clock of the frame
//   uart_state   - busy while a frame is in flight
module uart_tx_param
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int          DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              send_en,
    input  logic [2:0]        baud_set,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic              rs232_tx,
    output logic              tx_done,
    output logic              uart_state
);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [3:0]        bit_cnt;
    logic              stop2_q;
    logic              tx_q;
    logic              bit_end;
    logic              accept;
    logic              last_data;
    logic              last_stop;
    logic              has_par;
    logic              par_bit;

    assign accept     = (state == ST_IDLE) && send_en;
    assign last_data  = (bit_cnt == 4'(DATA_W - 1));
    assign last_stop  = (bit_cnt[0] == stop2_q);
    assign rs232_tx   = tx_q;
    assign uart_state = (state != ST_IDLE);
    // Combinational so the pulse lands one clock before the return to idle.
    assign tx_done    = bit_end && (state == ST_STOP) && last_stop && !rst;

    uart_baud_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .idle     (state == ST_IDLE),
        .load     (accept),
        .baud_set (baud_set),
        .bit_end  (bit_end)
    );

`ifdef UART_TX_PARITY_EN
    logic [1:0] par_mode_q;
    logic       par_acc;

    assign has_par = (par_mode_q == PAR_ODD) || (par_mode_q == PAR_EVEN);
    // tx_q still holds the last data bit when the parity bit is chosen, so
    // fold it in here rather than waiting for the accumulator to update.
    assign par_bit = par_acc ^ tx_q ^ (par_mode_q == PAR_ODD);

    always_ff @(posedge clk) begin
        if (rst) begin
            par_mode_q <= PAR_NONE;
            par_acc    <= 1'b0;
        end else if (accept) begin
            par_mode_q <= parity_mode;
            par_acc    <= 1'b0;
        end else if (bit_end && state == ST_DATA) begin
            par_acc <= par_acc ^ tx_q;
        end
    end
`else
    logic unused_parity;

    assign has_par       = 1'b0;
    assign par_bit       = 1'b0;
    assign unused_parity = ^parity_mode;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (send_en) begin
                        shreg   <= data_in;
                        stop2_q <= stop2;
                        bit_cnt <= '0;
                        tx_q    <= 1'b0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tx_q  <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (last_data) begin
                            bit_cnt <= '0;
                            if (has_par) begin
                                tx_q  <= par_bit;
                                state <= ST_PARITY;
                            end else begin
                                tx_q  <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            tx_q    <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        tx_q  <= 1'b1;
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        if (last_stop)
                            state <= ST_IDLE;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed bench for uart_tx_param at 50 MHz, with one
// 8-bit instance and one 9-bit instance sharing clock, reset and config.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d8;
    logic [8:0] d9;
    logic       se8, se9;
    logic [2:0] baud_set;
    logic [1:0] parity_mode;
    logic       stop2;
    logic       tx8, done8, busy8;
    logic       tx9, done9, busy9;
    logic       sel9;
    logic       line, done, busy;

    int tests = 0;
    int fails = 0;

    always #10 clk = ~clk;

    assign line = sel9 ? tx9   : tx8;
    assign done = sel9 ? done9 : done8;
    assign busy = sel9 ? busy9 : busy8;

    uart_tx_param #(.CLK_FREQ(50_000_000), .DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .data_in(d8), .send_en(se8), .baud_set(baud_set),
        .parity_mode(parity_mode), .stop2(stop2),
        .rs232_tx(tx8), .tx_done(done8), .uart_state(busy8)
    );

    uart_tx_param #(.CLK_FREQ(50_000_000), .DATA_W(9)) dut9 (
        .clk(clk), .rst(rst), .data_in(d9), .send_en(se9), .baud_set(baud_set),
        .parity_mode(parity_mode), .stop2(stop2),
        .rs232_tx(tx9), .tx_done(done9), .uart_state(busy9)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame bit k at index k; bits past the frame stay 1 (stop/idle level).
    function automatic logic [11:0] mk(input logic [8:0] data, input int w,
                                       input int par);
        logic [11:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < w; i++) f[1 + i] = data[i];
        if (par >= 0) f[1 + w] = par[0];
        return f;
    endfunction

    task automatic set_se(input bit use9, input logic v);
        if (use9) se9 = v; else se8 = v;
    endtask

    // Sends one frame and checks every bit at its first and last clock,
    // busy throughout, and exactly one tx_done in the last clock.
    // poke_at > 0 raises send_en at edge A+poke_at; poke_done raises it at
    // the edge that closes the tx_done cycle.
    task automatic frame(input bit use9, input logic [8:0] data, input int nb,
                         input logic [11:0] exp, input int div, input logic [2:0] bs,
                         input logic [1:0] pm, input logic s2, input int poke_at,
                         input bit poke_done, input string tag);
        int cyc, dcnt, blo;
        sel9 = use9;
        @(negedge clk);
        d8 = data[7:0]; d9 = data; baud_set = bs; parity_mode = pm; stop2 = s2;
        set_se(use9, 1'b1);
        @(posedge clk); #1;
        set_se(use9, 1'b0);
        // Scramble everything latched at accept.
        d8 = ~d8; d9 = ~d9; baud_set = bs ^ 3'b101; parity_mode = ~pm; stop2 = ~s2;
        cyc = 0; dcnt = 0; blo = 0;
        chk({tag, " accept busy"}, busy, 1);
        for (int k = 0; k < nb; k++) begin
            chk($sformatf("%s bit%0d head", tag, k), line, exp[k]);
            dcnt += int'(done);
            for (int j = 1; j < div; j++) begin
                @(posedge clk); #1; cyc++;
                set_se(use9, (poke_at > 0) && (cyc == poke_at - 1));
                dcnt += int'(done);
                blo  += int'(!busy);
            end
            chk($sformatf("%s bit%0d tail", tag, k), line, exp[k]);
            chk($sformatf("%s bit%0d done", tag, k), done, (k == nb - 1));
            if (k == nb - 1 && poke_done) set_se(use9, 1'b1);
            @(posedge clk); #1; cyc++;
            set_se(use9, 1'b0);
        end
        chk({tag, " end busy"}, busy, 0);
        chk({tag, " end line"}, line, 1);
        chk({tag, " end done"}, done, 0);
        chk({tag, " done count"}, dcnt, 1);
        chk({tag, " busy drops"}, blo, 0);
    endtask

    initial begin
        int dcnt, p;
        rst = 1'b1; d8 = '0; d9 = '0; se8 = 0; se9 = 0;
        baud_set = 3'd4; parity_mode = 2'b00; stop2 = 0; sel9 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset tx8", tx8, 1);     chk("reset busy8", busy8, 0);
        chk("reset done8", done8, 0); chk("reset tx9", tx9, 1);
        chk("reset busy9", busy9, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 0xAA, no parity, 1 stop; ignored pokes at A+100 and in tx_done cycle.
        frame(0, 9'h0AA, 10, 12'hF54, 434, 3'd4, 2'b00, 0, 100, 1, "t1");
        repeat (3) @(posedge clk);
        #1;
        chk("t1 stays idle", busy8, 0);

        // Reset at A+2000 during an all-zero payload.
        @(negedge clk);
        d8 = 8'h00; baud_set = 3'd4; parity_mode = 2'b00; stop2 = 0; se8 = 1;
        @(posedge clk); #1;
        se8 = 0; dcnt = 0;
        repeat (1999) begin
            @(posedge clk); #1;
            dcnt += int'(done8);
        end
        chk("t5 line low pre-reset", tx8, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5 line after reset", tx8, 1);
        chk("t5 busy after reset", busy8, 0);
        dcnt += int'(done8);
        repeat (100) begin
            @(posedge clk); #1;
            dcnt += int'(done8);
        end
        chk("t5 no done", dcnt, 0);
        chk("t5 idle line", tx8, 1);

        // 0x55 even parity (parity bit 0), then odd (parity bit 1).
        p = PAR_ON ? 0 : -1;
        frame(0, 9'h055, PAR_ON ? 11 : 10, mk(9'h055, 8, p), 434, 3'd4, 2'b10, 0, 0, 0, "t2e");
        repeat (2) @(posedge clk);
        #1;
        p = PAR_ON ? 1 : -1;
        frame(0, 9'h055, PAR_ON ? 11 : 10, mk(9'h055, 8, p), 434, 3'd4, 2'b01, 0, 0, 0, "t2o");

        // 0x55 two stop bits, then back-to-back frame at A+N*DIV+1 with mode 11.
        frame(0, 9'h055, 11, mk(9'h055, 8, -1), 434, 3'd4, 2'b00, 1, 0, 0, "t3");
        frame(0, 9'h0A5, 10, mk(9'h0A5, 8, -1), 434, 3'd4, 2'b11, 0, 0, 0, "t3b");

        // 9-bit all ones at 9600, odd parity -> parity bit 0.
        p = PAR_ON ? 0 : -1;
        frame(1, 9'h1FF, PAR_ON ? 12 : 11, mk(9'h1FF, 9, p), 5208, 3'd0, 2'b01, 0, 0, 0, "t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
